fd_pipe_buffer: RTL and testbench
=================================

// Module: fd_pipe_buffer
// PURPOSE
//  Fetch->decode pipeline stage; successor to the single-entry fetch/decode register.
//  Holds up to DEPTH {pc,inst} beats in a small circular buffer with valid/ready on both sides.
//  Kills all held beats on flush / interrupt and captures the architectural resume PC.
//  Sits between the fetch unit (upstream) and decode/execute (downstream); replaces stall/flush regs.
// PARAMETERS
//  XLEN      32             pc/inst width
//  DEPTH     2              buffer entries, >=1 (DEPTH>=2 sustains 1 beat/cycle)
//  NOP_INST  32'h0000_0033  bubble encoding (add x0,x0,x0) driven when empty
// PORTS
//  clk           in   1     clock, all state on posedge
//  reset         in   1     asynchronous, active-high; clears all state
//  pc_in         in   XLEN  upstream pc
//  inst_in       in   XLEN  upstream instruction
//  in_valid      in   1     upstream beat valid
//  in_ready      out  1     buffer can accept a beat
//  pc_out        out  XLEN  head pc ('0 when !out_valid)
//  inst_out      out  XLEN  head inst (NOP_INST when !out_valid)
//  out_valid     out  1     head beat valid
//  out_ready     in   1     downstream accepts (low == stall)
//  flush         in   1     branch/jump redirect kill
//  intrpt        in   1     external interrupt kill
//  timer_intrpt  in   1     timer interrupt kill
//  resume_pc     out  XLEN  oldest unconsumed pc at last interrupt kill
//  resume_vld    out  1     1-cycle pulse, cycle after an interrupt kill
// BEHAVIOUR
//  - Reset: count/rd_ptr/wr_ptr/storage/resume_pc/last_pc=0, resume_vld=0 -> out_valid=0, in_ready=1,
//    inst_out=NOP_INST, pc_out=0. Reset mid-burst discards everything, no pulse.
//  - in_ready = (count<DEPTH), registered-state only; no comb path from out_ready (full+pop => no push).
//  - out_valid = (count!=0); pc_out/inst_out from head slot; all outputs derive from flops only.
//  - kill = flush|intrpt|timer_intrpt. push = in_valid&in_ready&!kill; pop = out_valid&out_ready.
//  - Normal: push writes slot wr_ptr; pop advances rd_ptr; push+pop same cycle keeps count.
//    Latency in->out 1 cycle (beat visible cycle after push). Pointers wrap DEPTH-1 -> 0 (any DEPTH).
//  - On pop, last_pc <= head pc + 4 (XLEN wrap-around modulo 2^XLEN).
//  - Kill cycle: next count=0, rd_ptr=wr_ptr=0; incoming beat dropped; a pop in the same cycle
//    counts as consumed (downstream kills its own copy). Stall has no effect on a kill.
//  - Interrupt kill (intrpt|timer_intrpt, flush ignored for capture): resume_pc <= first of
//    {head if !pop, entry rd_ptr+1 if pop&count>1, pc_in if in_valid, else last_pc-on-this-edge
//    (head+4 if pop)}; resume_vld=1 next cycle only. Back-to-back interrupts re-capture each cycle.
//  - Kill asserted while empty: still clears pointers; interrupt still pulses resume_vld.
// CONFIGURATION
//  FD_BUF_PERF_EN defined: adds outputs stall_cnt[31:0] (cycles out_valid&!out_ready) and
//  kill_cnt[31:0] (kill cycles); both saturate at 32'hFFFF_FFFF, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package riscv_pipe_pkg: NOP_INST constant, typedef struct packed {pc,inst} fd_entry_t.
//  Storage array, pointers, resume logic inline. One sub-module: sat_counter (32-bit
//  saturating inc), instantiated twice only under FD_BUF_PERF_EN.
// TESTING
//  1 Reset held 3 cycles, release -> out_valid=0, inst_out=32'h33, pc_out=0, in_ready=1.
//  2 DEPTH=2, in_valid each cycle pc 0x0,0x4,0x8.., out_ready=1 -> one beat/cycle, out pc lags 1 cycle.
//  3 Push 0x100,0x104, out_ready=0 -> in_ready=0 after 2 pushes, head holds 0x100; raise out_ready
//    -> 0x100 then 0x104 delivered, in_ready=1 one cycle after first pop.
//  4 Buffer {0x200,0x204}, flush with pop -> next cycle out_valid=0, inst_out=32'h33, resume_vld=0.
//  5 Buffer {0x300,0x304}, timer_intrpt with pop -> resume_pc=0x304, resume_vld pulses 1 cycle.
//  6 Empty, no in_valid, last pop pc 0xFFFF_FFFC, intrpt -> resume_pc=0x0; with FD_BUF_PERF_EN
//    kill_cnt increments by 1 and stall_cnt counts stalled cycles of test 3.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary: the bubble encoding and the buffered beat.
package riscv_pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [PIPE_XLEN-1:0] NOP_INST = 32'h0000_0033;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] inst;
    } fd_entry_t;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that holds at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fd_pipe_buffer.sv
// Fetch->decode circular beat buffer with flush/interrupt kill and resume-PC capture.
// Define FD_BUF_PERF_EN to add saturating stall_cnt / kill_cnt outputs.
module fd_pipe_buffer
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned          XLEN     = PIPE_XLEN,
    parameter int unsigned          DEPTH    = 2,
    parameter logic [XLEN-1:0]      NOP_INST = riscv_pipe_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inst_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    input  logic            intrpt,
    input  logic            timer_intrpt,
    output logic [XLEN-1:0] resume_pc,
    output logic            resume_vld
`ifdef FD_BUF_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     kill_cnt
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fd_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] resume_pc_q, resume_pc_d, last_pc_q, last_pc_d;
    logic            resume_vld_q;

    logic      kill, irq_kill, push, pop;
    fd_entry_t head, second;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign kill     = flush | intrpt | timer_intrpt;
    assign irq_kill = intrpt | timer_intrpt;
    assign in_ready = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push     = in_valid & in_ready & ~kill;
    assign pop      = out_valid & out_ready;
    assign head     = mem_q[rd_ptr_q];
    assign second   = mem_q[ptr_inc(rd_ptr_q)];

    assign pc_out     = out_valid ? head.pc : '0;
    assign inst_out   = out_valid ? head.inst : NOP_INST;
    assign resume_pc  = resume_pc_q;
    assign resume_vld = resume_vld_q;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        last_pc_d   = last_pc_q;
        resume_pc_d = resume_pc_q;
        if (pop) begin
            last_pc_d = head.pc + XLEN'(4);
        end
        if (kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // Oldest beat not yet consumed by decode is where execution resumes.
        if (irq_kill) begin
            if (out_valid && !pop) begin
                resume_pc_d = head.pc;
            end else if (pop && (count_q > CW'(1))) begin
                resume_pc_d = second.pc;
            end else if (in_valid) begin
                resume_pc_d = pc_in;
            end else begin
                resume_pc_d = last_pc_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            resume_pc_q  <= '0;
            resume_vld_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{pc: pc_in, inst: inst_in};
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            last_pc_q    <= last_pc_d;
            resume_pc_q  <= resume_pc_d;
            resume_vld_q <= irq_kill;
        end
    end

`ifdef FD_BUF_PERF_EN
    sat_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (out_valid & ~out_ready),
        .cnt_o (stall_cnt)
    );

    sat_counter u_kill_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (kill),
        .cnt_o (kill_cnt)
    );
`endif

endmodule

// File: tb/tb_fd_pipe_buffer.sv
// Directed + short random bench for fd_pipe_buffer using a beat scoreboard queue.
module tb_fd_pipe_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0, inst_in = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        flush = 1'b0, intrpt = 1'b0, timer_intrpt = 1'b0;
    logic        in_ready, out_valid, resume_vld;
    logic [31:0] pc_out, inst_out, resume_pc;
`ifdef FD_BUF_PERF_EN
    logic [31:0] stall_cnt, kill_cnt;
`endif

    fd_pipe_buffer #(.XLEN(32), .DEPTH(DEPTH), .NOP_INST(32'h0000_0033)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_out       (pc_out),
        .inst_out     (inst_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flush        (flush),
        .intrpt       (intrpt),
        .timer_intrpt (timer_intrpt),
        .resume_pc    (resume_pc),
        .resume_vld   (resume_vld)
`ifdef FD_BUF_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .kill_cnt     (kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sb_pc[$];
    logic [31:0] sb_inst[$];
    logic [31:0] exp_rpc = '0, exp_last = '0;
    logic        exp_rvld = 1'b0;
    int          exp_stall = 0, exp_kill = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] epc, einst;
        epc   = (sb_pc.size() != 0) ? sb_pc[0] : 32'h0;
        einst = (sb_pc.size() != 0) ? sb_inst[0] : 32'h0000_0033;
        chk("out_valid", 32'(out_valid), 32'(sb_pc.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb_pc.size() < DEPTH));
        chk("pc_out", pc_out, epc);
        chk("inst_out", inst_out, einst);
        chk("resume_vld", 32'(resume_vld), 32'(exp_rvld));
        chk("resume_pc", resume_pc, exp_rpc);
`ifdef FD_BUF_PERF_EN
        chk("stall_cnt", stall_cnt, 32'(exp_stall));
        chk("kill_cnt", kill_cnt, 32'(exp_kill));
`endif
    endtask

    // Check current outputs, advance the scoreboard by the inputs now driven, then clock.
    task automatic tick();
        logic        pop, push, kill, irq;
        logic [31:0] cap;
        check_outputs();
        pop  = (sb_pc.size() != 0) && out_ready;
        kill = flush || intrpt || timer_intrpt;
        irq  = intrpt || timer_intrpt;
        push = in_valid && (sb_pc.size() < DEPTH) && !kill;
        if (sb_pc.size() != 0 && !out_ready) exp_stall++;
        if (kill) exp_kill++;
        cap = exp_rpc;
        if (sb_pc.size() != 0 && !pop)       cap = sb_pc[0];
        else if (pop && sb_pc.size() > 1)    cap = sb_pc[1];
        else if (in_valid)                   cap = pc_in;
        else if (pop)                        cap = sb_pc[0] + 32'd4;
        else                                 cap = exp_last;
        if (pop) begin
            exp_last = sb_pc[0] + 32'd4;
            void'(sb_pc.pop_front());
            void'(sb_inst.pop_front());
        end
        if (kill) begin
            sb_pc.delete();
            sb_inst.delete();
        end else if (push) begin
            sb_pc.push_back(pc_in);
            sb_inst.push_back(inst_in);
        end
        exp_rvld = irq;
        if (irq) exp_rpc = cap;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        in_valid  = v;
        pc_in     = pc;
        inst_in   = inst_of(pc);
        out_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        flush = 1'b0; intrpt = 1'b0; timer_intrpt = 1'b0;
        sb_pc.delete();
        sb_inst.delete();
        exp_rpc = '0; exp_last = '0; exp_rvld = 1'b0; exp_stall = 0; exp_kill = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset
        do_reset();
        chk("rst_inst_nop", inst_out, 32'h0000_0033);

        // 2: streaming at one beat per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();

        // 3: fill under stall, overflow attempt rejected, then drain
        drive(1'b1, 32'h100, 1'b0); tick();
        drive(1'b1, 32'h104, 1'b0); tick();
        chk("full_in_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 32'h108, 1'b0); tick();
        chk("stall_head", pc_out, 32'h100);
        drive(1'b0, 32'h0, 1'b1); tick();
        chk("first_pop_ready", 32'(in_ready), 32'h1);
        chk("second_beat", pc_out, 32'h104);
        tick();
        tick();

        // 4: flush with pop; incoming beat dropped, no resume pulse
        drive(1'b1, 32'h200, 1'b0); tick();
        drive(1'b1, 32'h204, 1'b0); tick();
        drive(1'b1, 32'h208, 1'b1); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, 32'h0, 1'b1);
        chk("flush_empty", 32'(out_valid), 32'h0);
        chk("flush_nop", inst_out, 32'h0000_0033);
        chk("flush_no_pulse", 32'(resume_vld), 32'h0);
        tick();

        // 5: timer interrupt with pop resumes at the second entry
        drive(1'b1, 32'h300, 1'b0); tick();
        drive(1'b1, 32'h304, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1); timer_intrpt = 1'b1; tick();
        timer_intrpt = 1'b0;
        chk("timer_resume_pc", resume_pc, 32'h304);
        chk("timer_resume_vld", 32'(resume_vld), 32'h1);
        tick();
        chk("timer_pulse_end", 32'(resume_vld), 32'h0);

        // 6: interrupt while empty resumes at last popped pc + 4, wrapping
        drive(1'b1, 32'hFFFF_FFFC, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b1); tick();
        intrpt = 1'b1; tick();
        intrpt = 1'b0;
        chk("wrap_resume_pc", resume_pc, 32'h0);
        chk("wrap_resume_vld", 32'(resume_vld), 32'h1);
        tick();

        // Back-to-back interrupts re-capture from pc_in each cycle
        intrpt = 1'b1;
        drive(1'b1, 32'h400, 1'b1); tick();
        drive(1'b1, 32'h404, 1'b1); tick();
        intrpt = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        chk("b2b_resume_pc", resume_pc, 32'h404);
        tick();

        // Randomized traffic with occasional kills
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 32'(32'h1000 + i * 4), 1'($urandom_range(0, 1)));
            flush        = ($urandom_range(0, 9) == 0);
            intrpt       = ($urandom_range(0, 11) == 0);
            timer_intrpt = ($urandom_range(0, 13) == 0);
            tick();
        end
        flush = 1'b0; intrpt = 1'b0; timer_intrpt = 1'b0;

        // Reset mid-burst discards beats and the pending pulse
        drive(1'b1, 32'h500, 1'b0); tick();
        drive(1'b1, 32'h504, 1'b0); intrpt = 1'b1; tick();
        intrpt = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_pulse", 32'(resume_vld), 32'h0);
        do_reset();
        drive(1'b1, 32'h600, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b1); tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
